hazard_stall_unit: RTL and testbench

Companion to the bypass/hazard controller. It produces every pipeline freeze and bubble that forwarding cannot cover: load-use interlock, the multi-cycle multiply/divide wait, and the control flush on a taken branch or jump. Inputs are the FD and DX instruction latches and the multdiv handshake. Outputs drive the PC, FD, DX and XM latch enables and the nop-insert muxes.

---
 rtl/hazard_stall_unit.sv | 179 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall, bubble and flush control for load-use, multdiv and taken branches
module hazard_stall_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [31:0]      inFD,
  input  logic [31:0]      inDX,
  input  logic             md_ready,
  input  logic             branch_taken,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             nop_dx,
  output logic             nop_xm,
  output logic             flush_fd,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // Opcode and ALU-op encodings of the ISA.
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Wait counter sized to hold MD_TIMEOUT-1; MD_TIMEOUT is at least 2.
  localparam int         MW      = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MW-1:0] CNT_LAST = MW'(MD_TIMEOUT - 1);
  localparam logic [MW-1:0] CNT_ONE  = MW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_RUN  = 2'd1,
    ST_MD_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Instruction field decode.
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
  logic [4:0] dx_op, dx_rd, dx_alu;

  assign fd_op  = inFD[31:27];
  assign fd_rd  = inFD[26:22];
  assign fd_rs  = inFD[21:17];
  assign fd_rt  = inFD[16:12];
  assign fd_alu = inFD[6:2];
  assign dx_op  = inDX[31:27];
  assign dx_rd  = inDX[26:22];
  assign dx_alu = inDX[6:2];

  // Instruction bits the hazard logic never looks at.
  logic unused_bits;
  assign unused_bits = ^{inFD[11:7], inFD[1:0], inDX[21:7], inDX[1:0]};

  logic dx_md;
  logic dx_lw;
  logic fd_reads_rs, fd_reads_rt, fd_reads_rd;
  logic load_use;

  // Classify the DX instruction and which FD source fields are live.
  always_comb begin
    dx_md = (dx_op == OP_ALU) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));
    dx_lw = (dx_op == OP_LW) && (dx_rd != 5'd0);

    fd_reads_rs = (fd_op == OP_ALU) || (fd_op == OP_ADDI) || (fd_op == OP_SW) ||
                  (fd_op == OP_LW)  || (fd_op == OP_BNE)  || (fd_op == OP_BLT);
    fd_reads_rt = (fd_op == OP_ALU) && (fd_alu != ALU_SLL) && (fd_alu != ALU_SRA);
    fd_reads_rd = (fd_op == OP_SW)  || (fd_op == OP_BNE)  || (fd_op == OP_BLT) ||
                  (fd_op == OP_JR);

    load_use = dx_lw && ((fd_reads_rs && (fd_rs == dx_rd)) ||
                         (fd_reads_rt && (fd_rt == dx_rd)) ||
                         (fd_reads_rd && (fd_rd == dx_rd)));
  end

  // Multdiv sequencer next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dx_md) begin
          state_d = ST_MD_RUN;
          cnt_d   = '0;
        end
      end
      ST_MD_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (md_ready) begin
          state_d = ST_MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_MD_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_MD_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline control: md wait dominates, then branch flush, then load-use bubble.
  always_comb begin
    stall_pc = 1'b0;
    stall_fd = 1'b0;
    stall_dx = 1'b0;
    nop_dx   = 1'b0;
    nop_xm   = 1'b0;
    flush_fd = 1'b0;
    md_start = 1'b0;
    if (resetn) begin
      if (state_q == ST_MD_RUN) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        stall_dx = 1'b1;
        nop_xm   = 1'b1;
      end else begin
        // Only IDLE may launch; MD_DONE lets the finished mul/div leave DX.
        md_start = (state_q == ST_IDLE) && dx_md;
        if (branch_taken) begin
          flush_fd = 1'b1;
          nop_dx   = 1'b1;
        end else if (load_use) begin
          stall_pc = 1'b1;
          stall_fd = 1'b1;
          nop_dx   = 1'b1;
        end
      end
    end
  end

  // Saturating count of PC-hold cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset abandons any outstanding multdiv operation.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy      = (state_q == ST_MD_RUN);
  assign md_timeout   = timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  logic        clock;
  logic        resetn;
  logic [31:0] inFD;
  logic [31:0] inDX;
  logic        md_ready;
  logic        branch_taken;
  logic        stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd;
  logic        md_start, md_busy, md_timeout;
  logic [15:0] stall_cycles;

  int checks;
  int errors;
  int exp_sc;

  hazard_stall_unit #(.MD_TIMEOUT(64), .CNT_W(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .inFD         (inFD),
    .inDX         (inDX),
    .md_ready     (md_ready),
    .branch_taken (branch_taken),
    .stall_pc     (stall_pc),
    .stall_fd     (stall_fd),
    .stall_dx     (stall_dx),
    .nop_dx       (nop_dx),
    .nop_xm       (nop_xm),
    .flush_fd     (flush_fd),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_timeout   (md_timeout),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  // Packs the seven combinational controls as {stall_pc,stall_fd,stall_dx,nop_dx,nop_xm,flush_fd,md_start}.
  function automatic logic [6:0] ctl();
    return {stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd, md_start};
  endfunction

  task automatic test_reset();
    logic [6:0] c;
    resetn = 1'b0; inFD = 32'd0; inDX = 32'd0; md_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(negedge clock);
    inDX = instr(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00110);
    #1;
    c = ctl();
    checks++;
    if (c !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b want 0000000", c); end
    checks++;
    if ({md_busy, md_timeout, stall_cycles} !== 18'd0) begin
      errors++; $display("FAIL reset_regs got busy=%b to=%b sc=%0d want 0", md_busy, md_timeout, stall_cycles);
    end
    inDX = 32'd0;
    @(negedge clock);
    resetn = 1'b1;
    exp_sc = 0;
    @(negedge clock);
  endtask

  task automatic test_load_use();
    logic [6:0] c;
    inDX = instr(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
    inFD = instr(5'b00000, 5'd3, 5'd5, 5'd2, 5'b00000);
    #1;
    c = ctl();
    checks++;
    if (c !== 7'b1101000) begin errors++; $display("FAIL load_use_stall got %b want 1101000", c); end
    exp_sc++;
    @(negedge clock);
    inDX = 32'd0;
    #1;
    c = ctl();
    checks++;
    if (c !== 7'b0) begin errors++; $display("FAIL load_use_release got %b want 0000000", c); end
    checks++;
    if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL load_use_count got %0d want %0d", stall_cycles, exp_sc); end
    @(negedge clock);
  endtask

  task automatic test_field_use();
    logic [6:0] c;
    inDX = instr(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
    inFD = instr(5'b00000, 5'd3, 5'd0, 5'd0, 5'b00000);
    #1; c = ctl();
    checks++;
    if (c !== 7'b0) begin errors++; $display("FAIL lw_r0 got %b want 0000000", c); end
    @(negedge clock);
    inDX = instr(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
    inFD = instr(5'b00000, 5'd3, 5'd1, 5'd5, 5'b00100);
    #1; c = ctl();
    checks++;
    if (c !== 7'b0) begin errors++; $display("FAIL sll_rt_unused got %b want 0000000", c); end
    @(negedge clock);
    inFD = instr(5'b00111, 5'd5, 5'd1, 5'd0, 5'd0);
    #1; c = ctl();
    checks++;
    if (c !== 7'b1101000) begin errors++; $display("FAIL sw_rd_read got %b want 1101000", c); end
    exp_sc++;
    @(negedge clock);
    inDX = 32'd0; inFD = 32'd0;
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL field_count got %0d want %0d", stall_cycles, exp_sc); end
    @(negedge clock);
  endtask

  task automatic test_branch();
    logic [6:0] c;
    inDX = instr(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
    inFD = instr(5'b00000, 5'd3, 5'd5, 5'd2, 5'b00000);
    branch_taken = 1'b1;
    #1; c = ctl();
    checks++;
    if (c !== 7'b0001010) begin errors++; $display("FAIL branch_over_load_use got %b want 0001010", c); end
    @(negedge clock);
    branch_taken = 1'b0; inDX = 32'd0; inFD = 32'd0;
    #1;
    checks++;
    if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL branch_count got %0d want %0d", stall_cycles, exp_sc); end
    @(negedge clock);
  endtask

  // Runs one mul with md_ready raised in run cycle n; leaves DUT in MD_DONE with mul still in DX.
  task automatic run_mul(input int n, input string tag);
    logic [6:0] c;
    int bad;
    inDX = instr(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
    md_ready = 1'b0;
    #1; c = ctl();
    checks++;
    if (c !== 7'b0000001 || md_busy !== 1'b0) begin
      errors++; $display("FAIL %s_start got %b busy=%b want 0000001 busy=0", tag, c, md_busy);
    end
    @(negedge clock);
    bad = 0;
    for (int i = 1; i <= n; i++) begin
      md_ready = (i == n);
      #1; c = ctl();
      if (c !== 7'b1110100 || md_busy !== 1'b1) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_run got %0d bad cycles want 0", tag, bad); end
    exp_sc += n;
    md_ready = 1'b0;
    #1; c = ctl();
    checks++;
    if (c !== 7'b0 || md_busy !== 1'b0) begin
      errors++; $display("FAIL %s_done got %b busy=%b want 0000000 busy=0", tag, c, md_busy);
    end
    checks++;
    if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL %s_count got %0d want %0d", tag, stall_cycles, exp_sc); end
  endtask

  task automatic test_mul();
    run_mul(5, "mul5");
    inDX = 32'd0;
    @(negedge clock);
    checks++;
    if (md_timeout !== 1'b0 || md_busy !== 1'b0 || md_start !== 1'b0) begin
      errors++; $display("FAIL mul5_idle got to=%b busy=%b start=%b want 0 0 0", md_timeout, md_busy, md_start);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    run_mul(2, "b2b_first");
    @(negedge clock);
    run_mul(1, "b2b_second");
    inDX = 32'd0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int run_cnt;
    inDX = instr(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00111);
    md_ready = 1'b0;
    @(negedge clock);
    run_cnt = 0;
    for (int i = 0; i < 100 && md_busy; i++) begin
      run_cnt++;
      @(negedge clock);
    end
    exp_sc += run_cnt;
    checks++;
    if (run_cnt != 64) begin errors++; $display("FAIL timeout_len got %0d want 64", run_cnt); end
    checks++;
    if (md_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b want 1", md_timeout); end
    inDX = 32'd0;
    @(negedge clock);
    run_mul(3, "post_to");
    inDX = 32'd0;
    @(negedge clock);
    checks++;
    if (md_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", md_timeout); end
    checks++;
    if (stall_cycles !== 16'(exp_sc)) begin errors++; $display("FAIL timeout_count got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] c;
    inDX = instr(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00110);
    md_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL mid_run_busy got %b want 1", md_busy); end
    resetn = 1'b0;
    #1; c = ctl();
    checks++;
    if (c !== 7'b0 || {md_busy, md_timeout, stall_cycles} !== 18'd0) begin
      errors++; $display("FAIL mid_run_reset got ctl=%b busy=%b to=%b sc=%0d want all 0", c, md_busy, md_timeout, stall_cycles);
    end
    exp_sc = 0;
    @(negedge clock);
    inDX = 32'd0; md_ready = 1'b1; resetn = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (md_busy !== 1'b0 || ctl() !== 7'b0) begin
      errors++; $display("FAIL late_ready got busy=%b ctl=%b want 0", md_busy, ctl());
    end
    @(negedge clock);
    md_ready = 1'b0;
    run_mul(2, "after_reset");
    inDX = 32'd0;
    @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0; exp_sc = 0;
    test_reset();
    test_load_use();
    test_field_use();
    test_branch();
    test_mul();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
